// File: rtl/flag_branch_controller_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Shared definitions for the execute-stage flag/branch controller:
//   flag bit positions inside the {C,N,Z} register, the two-bit branch type
//   encoding and the redirect FSM state type.
// ---------------------------------------------------------------------------
package branch_pkg;

    // Bit positions inside the 3-bit condition code register {C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    // Branch type encoding as presented on br_type
    typedef enum logic [1:0] {
        BR_JMP = 2'b00,
        BR_JZ  = 2'b01,
        BR_JN  = 2'b10,
        BR_JC  = 2'b11
    } br_type_e;

    // Redirect sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } state_e;

endpackage

// File: rtl/flag_branch_controller_if.sv
// ---------------------------------------------------------------------------
// flag_branch_controller_if
//   Bundles the ALU flag update, branch, interrupt save/restore and redirect
//   signals of the execute stage.
//   slave  : the controller (consumes ALU/branch/interrupt inputs, drives
//            flag, pc_redirect, pc_target, flush, busy, save_err)
//   master : whoever drives the execute-stage inputs
// ---------------------------------------------------------------------------
interface flag_branch_controller_if #(
    parameter int PC_WIDTH = 32
);
    logic [2:0]          alu_flag_we;
    logic [2:0]          alu_flag;
    logic                br_valid;
    logic [1:0]          br_type;
    logic [PC_WIDTH-1:0] br_target;
    logic                stall;
    logic                int_save;
    logic                int_restore;
    logic [2:0]          flag;
    logic                pc_redirect;
    logic [PC_WIDTH-1:0] pc_target;
    logic                flush;
    logic                busy;
    logic                save_err;

    modport slave (
        input  alu_flag_we, alu_flag, br_valid, br_type, br_target,
               stall, int_save, int_restore,
        output flag, pc_redirect, pc_target, flush, busy, save_err
    );

    modport master (
        output alu_flag_we, alu_flag, br_valid, br_type, br_target,
               stall, int_save, int_restore,
        input  flag, pc_redirect, pc_target, flush, busy, save_err
    );
endinterface

// File: rtl/flag_branch_controller_save_stack.sv
// ---------------------------------------------------------------------------
// flag_save_stack
//   Small LIFO holding 3-bit flag snapshots across nested interrupts.
//   Implemented as a shift register with the top of stack in entry 0, so the
//   popped value is always available combinationally on data_o.
//   Ports: clk, rst (async active-low), push_i/data_i, pop_i, data_o,
//          full_o, empty_o. Push when full and pop when empty are ignored;
//          the caller is responsible for flagging those as errors.
// ---------------------------------------------------------------------------
module flag_save_stack #(
    parameter int SAVE_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [2:0] data_i,
    output logic [2:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int CW = $clog2(SAVE_DEPTH + 1);

    logic [2:0]    mem_q [SAVE_DEPTH];
    logic [CW-1:0] count_q;

    assign full_o  = (count_q == CW'(SAVE_DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[0];

    // Push shifts everything one slot deeper; pop shifts it back up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SAVE_DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
        end else if (push_i && !full_o) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < SAVE_DEPTH; i++) mem_q[i] <= mem_q[i-1];
            count_q <= count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            for (int i = 0; i < SAVE_DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
            mem_q[SAVE_DEPTH-1] <= '0;
            count_q <= count_q - CW'(1);
        end
    end
endmodule

// File: rtl/flag_branch_controller.sv
// ---------------------------------------------------------------------------
// flag_branch_controller
//   Execute-stage owner of the {C,N,Z} flag register. Applies per-bit ALU
//   flag writes, resolves JMP/JZ/JN/JC against the bypassed flags (clearing
//   the tested bit), issues a registered PC redirect followed by a
//   FLUSH_CYCLES-long flush, and saves/restores flags across interrupts.
//   Ports: clk, rst (async active-low), bus (slave modport of
//          flag_branch_controller_if carrying all data/control signals).
// ---------------------------------------------------------------------------
module flag_branch_controller
    import branch_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int SAVE_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    flag_branch_controller_if.slave  bus
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          flag_q, flag_d;
    logic [PC_WIDTH-1:0] pc_target_q;
    logic                pc_redirect_q, flush_q, busy_q, save_err_q;

    logic [2:0] eff, clearMask, flagNormal, popData;
    logic       condBit, brAccept, brTaken;
    logic       doSave, doRestore, stackFull, stackEmpty, errEvent;

    // Bypass the ALU write into the flag view, decide whether a branch is
    // accepted/taken, and build the next flag value. A conditional branch
    // clears its tested bit whether or not it is taken; a successful restore
    // overrides everything else.
    always_comb begin
        eff        = (bus.alu_flag_we & bus.alu_flag) | (~bus.alu_flag_we & flag_q);
        brAccept   = !bus.stall && bus.br_valid && (state_q == IDLE);
        condBit    = 1'b1;
        clearMask  = 3'b000;
        case (br_type_e'(bus.br_type))
            BR_JZ:   begin condBit = eff[FLAG_Z]; clearMask[FLAG_Z] = 1'b1; end
            BR_JN:   begin condBit = eff[FLAG_N]; clearMask[FLAG_N] = 1'b1; end
            BR_JC:   begin condBit = eff[FLAG_C]; clearMask[FLAG_C] = 1'b1; end
            default: begin condBit = 1'b1;        clearMask = 3'b000;       end
        endcase
        brTaken    = brAccept && condBit;
        flagNormal = brAccept ? (eff & ~clearMask) : eff;
        doRestore  = !bus.stall && bus.int_restore;
        doSave     = !bus.stall && bus.int_save && !bus.int_restore;
        errEvent   = (doSave && stackFull) || (doRestore && stackEmpty);
        if (bus.stall)
            flag_d = flag_q;
        else if (doRestore && !stackEmpty)
            flag_d = popData;
        else
            flag_d = flagNormal;
    end

    // The stack snapshots the flag value this cycle would produce without
    // the restore, so a save coinciding with a branch captures the cleared bit.
    flag_save_stack #(
        .SAVE_DEPTH (SAVE_DEPTH)
    ) u_save_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (doSave),
        .pop_i   (doRestore),
        .data_i  (flagNormal),
        .data_o  (popData),
        .full_o  (stackFull),
        .empty_o (stackEmpty)
    );

    // Flag register and sticky save/restore error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q     <= '0;
            save_err_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
            if (errEvent) save_err_q <= 1'b1;
        end
    end

    // Redirect FSM with registered outputs. REDIRECT always lasts exactly one
    // cycle regardless of stall; the remaining FLUSH_CYCLES-1 flush cycles
    // only count down on unstalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pc_target_q   <= '0;
            pc_redirect_q <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (brTaken) begin
                        state_q       <= REDIRECT;
                        pc_target_q   <= bus.br_target;
                        cnt_q         <= CNT_W'(FLUSH_CYCLES - 1);
                        pc_redirect_q <= 1'b1;
                        flush_q       <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_redirect_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!bus.stall) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            flush_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    pc_redirect_q <= 1'b0;
                    flush_q       <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flag        = flag_q;
    assign bus.pc_redirect = pc_redirect_q;
    assign bus.pc_target   = pc_target_q;
    assign bus.flush       = flush_q;
    assign bus.busy        = busy_q;
    assign bus.save_err    = save_err_q;
endmodule

// File: tb/tb_flag_branch_controller.sv
// ---------------------------------------------------------------------------
// tb_flag_branch_controller
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model that tracks flags as a vector, the save stack as a
//   queue and the redirect as a count of remaining flush cycles.
// ---------------------------------------------------------------------------
module tb_flag_branch_controller;
    localparam int PC_WIDTH     = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int SAVE_DEPTH   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    flag_branch_controller_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    flag_branch_controller #(
        .PC_WIDTH     (PC_WIDTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .SAVE_DEPTH   (SAVE_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    logic [2:0]          mFlag;
    logic [2:0]          mStack[$];
    logic                mErr;
    logic [PC_WIDTH-1:0] mTarget;
    logic                mRedirect;
    int                  mFlushLeft;

    task automatic modelReset();
        mFlag      = 3'b000;
        mStack     = {};
        mErr       = 1'b0;
        mTarget    = '0;
        mRedirect  = 1'b0;
        mFlushLeft = 0;
    endtask

    // One clock edge of the intended behaviour, using the current inputs.
    task automatic modelStep();
        logic [2:0] eff, nxt;
        logic       taken;
        int         idx;
        taken = 1'b0;
        if (!bus.stall) begin
            eff = (bus.alu_flag_we & bus.alu_flag) | (~bus.alu_flag_we & mFlag);
            nxt = eff;
            if (bus.br_valid && !mRedirect && mFlushLeft == 0) begin
                if (bus.br_type == 2'b00) begin
                    taken = 1'b1;
                end else begin
                    idx      = int'(bus.br_type) - 1;
                    taken    = eff[idx];
                    nxt[idx] = 1'b0;
                end
            end
            if (bus.int_restore) begin
                if (mStack.size() > 0) nxt = mStack.pop_back();
                else mErr = 1'b1;
            end else if (bus.int_save) begin
                if (mStack.size() == SAVE_DEPTH) mErr = 1'b1;
                else mStack.push_back(nxt);
            end
            mFlag = nxt;
        end
        if (mRedirect) begin
            mRedirect  = 1'b0;
            mFlushLeft = mFlushLeft - 1;
        end else if (mFlushLeft > 0 && !bus.stall) begin
            mFlushLeft = mFlushLeft - 1;
        end
        if (taken) begin
            mRedirect  = 1'b1;
            mFlushLeft = FLUSH_CYCLES;
            mTarget    = bus.br_target;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".flag"},        32'(bus.flag),        32'(mFlag));
        checkVal({tag, ".pc_redirect"}, 32'(bus.pc_redirect), 32'(mRedirect));
        checkVal({tag, ".pc_target"},   32'(bus.pc_target),   32'(mTarget));
        checkVal({tag, ".flush"},       32'(bus.flush),       32'(mFlushLeft > 0));
        checkVal({tag, ".busy"},        32'(bus.busy),        32'(mFlushLeft > 0));
        checkVal({tag, ".save_err"},    32'(bus.save_err),    32'(mErr));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check.
    task automatic applyStimulus(input string tag, input logic [2:0] we, input logic [2:0] af,
                                 input logic bv, input logic [1:0] bt, input logic [31:0] tgt,
                                 input logic st, input logic sv, input logic rs);
        bus.alu_flag_we = we;
        bus.alu_flag    = af;
        bus.br_valid    = bv;
        bus.br_type     = bt;
        bus.br_target   = tgt;
        bus.stall       = st;
        bus.int_save    = sv;
        bus.int_restore = rs;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.alu_flag_we = '0;
        bus.alu_flag    = '0;
        bus.br_valid    = 1'b0;
        bus.br_type     = '0;
        bus.br_target   = '0;
        bus.stall       = 1'b0;
        bus.int_save    = 1'b0;
        bus.int_restore = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: ALU write of all three bits
        applyStimulus("t1.alu", 3'b111, 3'b101, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        idle("t1.hold");

        // 2: Z set, taken JZ to 0x40, redirect then flush
        applyStimulus("t2.setz", 3'b111, 3'b001, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t2.jz", 3'b000, 3'b000, 1'b1, 2'b01, 32'h40, 1'b0, 1'b0, 1'b0);
        idle("t2.flush");
        idle("t2.idle");
        idle("t2.idle2");

        // 3: JC not taken, then JC taken via same-cycle ALU bypass
        applyStimulus("t3.jcnt", 3'b000, 3'b000, 1'b1, 2'b11, 32'h80, 1'b0, 1'b0, 1'b0);
        applyStimulus("t3.jcbyp", 3'b100, 3'b100, 1'b1, 2'b11, 32'h84, 1'b0, 1'b0, 1'b0);
        idle("t3.flush");
        idle("t3.idle");

        // 4: set N, JMP, stall during FLUSH, JN while busy is ignored
        applyStimulus("t4.setn", 3'b010, 3'b010, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t4.jmp", 3'b000, 3'b000, 1'b1, 2'b00, 32'h100, 1'b0, 1'b0, 1'b0);
        applyStimulus("t4.redir", 3'b000, 3'b000, 1'b1, 2'b10, 32'h200, 1'b0, 1'b0, 1'b0);
        applyStimulus("t4.stall1", 3'b000, 3'b000, 1'b1, 2'b10, 32'h200, 1'b1, 1'b0, 1'b0);
        applyStimulus("t4.stall2", 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus("t4.jnbusy", 3'b000, 3'b000, 1'b1, 2'b10, 32'h200, 1'b0, 1'b0, 1'b0);
        idle("t4.idle");

        // 5: save 110, ALU overwrites, restore, then restore on empty stack
        applyStimulus("t5.set", 3'b111, 3'b110, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t5.save", 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("t5.alu", 3'b111, 3'b001, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t5.rest", 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus("t5.under", 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);

        // 6: overflow after reset, then reset asserted mid-flush
        doReset();
        applyStimulus("t6.s1", 3'b111, 3'b011, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("t6.s2", 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("t6.s3", 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("t6.jmp", 3'b000, 3'b000, 1'b1, 2'b00, 32'h300, 1'b0, 1'b0, 1'b0);
        applyStimulus("t6.redir", 3'b000, 3'b000, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("t6.asyncrst");
        @(negedge clk);
        rst = 1'b1;
        idle("t6.after");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                3'($urandom), 3'($urandom),
                1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0));
            if (i == 200) doReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
